// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter: N producers share one sync FIFO write port, one burst at a time.
// Optional per-requester accepted-beat counters when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arb #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_valid,
    input  logic [N-1:0]           req_last,
    input  logic [N*W-1:0]         req_data,
    output logic [N-1:0]           req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wen,
    output logic [W-1:0]           fifo_din,
    output logic                   grant_valid,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [N*16-1:0]        beat_total,
`endif
    output logic [$clog2(N)-1:0]   grant_id
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            gvalid_q, gvalid_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    int unsigned     arb_sum;

    logic            busy;
    logic            g_valid;
    logic            g_last;
    logic [W-1:0]    g_data;
    logic            beat;
    logic            burst_end;

    // Round-robin pick: first valid requester after rr_ptr, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        arb_sum   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            arb_sum = 32'(rr_ptr_q) + k;
            cand    = IW'(arb_sum % N);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Owner-side view of the request bus and the beat/release conditions.
    always_comb begin
        busy      = (state_q == BUSY);
        g_valid   = req_valid[gid_q];
        g_last    = req_last[gid_q];
        g_data    = req_data[32'(gid_q)*W +: W];
        beat      = busy && g_valid && !fifo_full;
        burst_end = beat && (g_last || ((cnt_q + CW'(1)) == CW'(MAX_BURST)));
    end

    // Write-port drive is a zero-cycle path from the owner's request; idle bus reads as zero.
    always_comb begin
        req_ready = '0;
        fifo_wen  = 1'b0;
        fifo_din  = '0;
        if (busy && !fifo_full) begin
            req_ready = N'(1) << gid_q;
        end
        if (beat) begin
            fifo_wen = 1'b1;
            fifo_din = g_data;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and release in BUSY.
    always_comb begin
        state_d  = state_q;
        gvalid_d = gvalid_q;
        gid_d    = gid_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = BUSY;
                    gvalid_d = 1'b1;
                    gid_d    = win_idx;
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (burst_end) begin
                    state_d  = IDLE;
                    gvalid_d = 1'b0;
                    rr_ptr_d = gid_q;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                gvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gvalid_q <= 1'b0;
            gid_q    <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= IW'(N - 1);
        end else begin
            state_q  <= state_d;
            gvalid_q <= gvalid_d;
            gid_q    <= gid_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_valid = gvalid_q;
    assign grant_id    = gid_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*16-1:0] beat_total_q, beat_total_d;

    // Per-requester accepted-beat counters; 16-bit wrap is intentional.
    always_comb begin
        beat_total_d = beat_total_q;
        if (beat) begin
            beat_total_d[32'(gid_q)*16 +: 16] = beat_total_q[32'(gid_q)*16 +: 16] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_total_q <= '0;
        end else begin
            beat_total_q <= beat_total_d;
        end
    end

    assign beat_total = beat_total_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios with literal expectations plus random traffic
// checked every cycle against a burst-level behavioural model.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int MB = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_wen;
    logic [W-1:0]     fifo_din;
    logic             grant_valid;
    logic [1:0]       grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [N*16-1:0]  beat_total;
`endif

    fifo_wr_arb #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wen    (fifo_wen),
        .fifo_din    (fifo_din),
        .grant_valid (grant_valid),
`ifdef FIFO_WR_ARB_STATS_EN
        .beat_total  (beat_total),
`endif
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst-level model: who owns the port, how many beats it has moved, who went last.
    bit m_run  = 1'b0;
    bit m_busy = 1'b0;
    int m_gid  = 0;
    int m_cnt  = 0;
    int m_rr   = N - 1;
    int m_seq [N];
    int m_tot [N];

    function automatic int pick(input int rr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            m_seq[i] = 0;
            m_tot[i] = 0;
        end
    end

    always @(posedge clk) begin
        int w;
        if (!rst_n) begin
            m_run  = 1'b1;
            m_busy = 1'b0;
            m_gid  = 0;
            m_cnt  = 0;
            m_rr   = N - 1;
            for (int i = 0; i < N; i++) m_tot[i] = 0;
        end else if (m_run) begin
            if (!m_busy) begin
                w = pick(m_rr, req_valid);
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_gid  = w;
                    m_cnt  = 0;
                end
            end else if (req_valid[m_gid] && !fifo_full) begin
                m_seq[m_gid] = (m_seq[m_gid] + 1) % 8;
                m_tot[m_gid] = (m_tot[m_gid] + 1) % 65536;
                m_cnt++;
                if (req_last[m_gid] || m_cnt == MB) begin
                    m_busy = 1'b0;
                    m_rr   = m_gid;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic         e_wen;
        logic [W-1:0] e_din;
        if (m_run) begin
            e_ready = '0;
            e_wen   = 1'b0;
            e_din   = '0;
            if (m_busy && !fifo_full) e_ready[m_gid] = 1'b1;
            if (m_busy && req_valid[m_gid] && !fifo_full) begin
                e_wen = 1'b1;
                e_din = req_data[m_gid*W +: W];
            end
            chk("grant_valid", 64'(grant_valid), 64'(m_busy));
            if (m_busy) chk("grant_id", 64'(grant_id), 64'(m_gid));
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("fifo_wen", 64'(fifo_wen), 64'(e_wen));
            chk("fifo_din", 64'(fifo_din), 64'(e_din));
`ifdef FIFO_WR_ARB_STATS_EN
            for (int i = 0; i < N; i++)
                chk("beat_total", 64'(beat_total[i*16 +: 16]), 64'(m_tot[i]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    int order [$];
    int exp2 [5]  = '{0, 1, 2, 3, 0};
    int exp3 [10] = '{2, 2, 2, 2, 3, 3, 3, 3, 2, 2};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Single requester, single-beat burst.
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data  = 12'h005;
        @(negedge clk);
        chk("t1_idle_gv", 64'(grant_valid), 64'd0);
        chk("t1_idle_wen", 64'(fifo_wen), 64'd0);
        tick();
        @(negedge clk);
        chk("t1_gid", 64'(grant_id), 64'd0);
        chk("t1_gv", 64'(grant_valid), 64'd1);
        chk("t1_wen", 64'(fifo_wen), 64'd1);
        chk("t1_din", 64'(fifo_din), 64'd5);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_release", 64'(grant_valid), 64'd0);

        // All requesters valid with single-beat bursts: strict rotation.
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 12'o7531;
        order.delete();
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            if (grant_valid && fifo_wen) order.push_back(int'(grant_id));
        end
        chk("t2_ngrants", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk("t2_order", 64'(order[i]), 64'(exp2[i]));

        // Unterminated stream from req 2 is cut at MAX_BURST; req 3 gets its turn.
        do_reset();
        req_valid = 4'b1100;
        req_last  = 4'b0000;
        req_data  = 12'o4300;
        order.delete();
        for (int c = 0; c < 12; c++) begin
            tick();
            @(negedge clk);
            if (fifo_wen) order.push_back(int'(grant_id));
        end
        chk("t3_nbeats", 64'(order.size()), 64'd10);
        for (int i = 0; i < 10 && i < order.size(); i++)
            chk("t3_seq", 64'(order[i]), 64'(exp3[i]));

        // Reset mid-burst drops the grant; rotation restarts from requester 0.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_gv", 64'(grant_valid), 64'd0);
        chk("t6_wen", 64'(fifo_wen), 64'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("t6_stats", 64'(beat_total), 64'd0);
`endif
        req_valid = 4'b1111;
        tick();
        @(negedge clk);
        chk("t6_first", 64'(grant_id), 64'd0);

        // Random traffic; producers present their own running sequence numbers.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                req_valid[i]        = ($urandom_range(0, 9) < 6);
                req_last[i]         = ($urandom_range(0, 3) == 0);
                req_data[i*W +: W]  = W'(m_seq[i]);
            end
            fifo_full = ($urandom_range(0, 4) == 0);
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
